vhdci_mux_arbiter: RTL and testbench

VHDCI_MUX_ARBITER -- requirements
Module: vhdci_mux_arbiter

---
 rtl/vhdci_mux_arbiter.sv | 224 ++++++++++++++++++++++
 tb/tb_vhdci_mux_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vhdci_mux_arbiter.sv
// vhdci_mux_arbiter: shares a 7-bit link payload among NUM_CH byte channels.
// Each TX byte is sent as a header word (channel + high nibble) followed by a
// tail word (parity + low nibble). Channels are served round-robin. The RX
// side reassembles header/tail pairs into bytes, checks the framing and the
// parity, and counts errors.
module vhdci_mux_arbiter #(
    parameter int NUM_CH = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  mux_synced_in,
    input  logic [NUM_CH-1:0]     tx_valid_in,
    input  logic [8*NUM_CH-1:0]   tx_data_in,
    output logic [NUM_CH-1:0]     tx_ready_out,
    output logic [6:0]            mux_data_out,
    input  logic [6:0]            mux_data_in,
    output logic [NUM_CH-1:0]     rx_valid_out,
    output logic [7:0]            rx_data_out,
    output logic                  tx_drop_out,
    output logic                  rx_err_out,
    output logic [7:0]            rx_err_cnt_out
);

    typedef enum logic {TX_ARB = 1'b0, TX_TAIL = 1'b1} tx_state_t;
    typedef enum logic {RX_WAIT_HEAD = 1'b0, RX_WAIT_TAIL = 1'b1} rx_state_t;

    tx_state_t   tx_state_reg, tx_state_next;
    rx_state_t   rx_state_reg, rx_state_next;

    logic [1:0]  last_grant_reg;
    logic [7:0]  tx_byte_reg;
    logic [6:0]  mux_data_reg, mux_data_next;
    logic        tx_drop_reg, tx_drop_next;
    logic        grant_found, grant_fire;
    logic [1:0]  grant_ch;
    logic [3:0]  valid_ext, ready_ext;
    logic [7:0]  ch_data [4];

    logic [1:0]        rx_ch_reg;
    logic [3:0]        rx_hi_reg;
    logic [NUM_CH-1:0] rx_valid_reg;
    logic [7:0]        rx_data_reg;
    logic              rx_err_reg;
    logic [7:0]        rx_err_cnt_reg;
    logic              word_head, word_tail;
    logic [7:0]        rx_byte;
    logic              rx_good, rx_err_next;
    logic [3:0]        rx_onehot;

    // Channel requests widened to the full 2-bit channel space so the
    // round-robin search can index with a 2-bit channel number.
    assign valid_ext = 4'(tx_valid_in);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_ch_data
            if (gi < NUM_CH) begin : g_used
                assign ch_data[gi] = tx_data_in[8*gi +: 8];
            end else begin : g_unused
                assign ch_data[gi] = 8'h00;
            end
        end
    endgenerate

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        logic [2:0] cand;
        cand        = '0;
        grant_found = 1'b0;
        grant_ch    = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand = {1'b0, last_grant_reg} + 3'(k);
            if (cand >= 3'(NUM_CH)) begin
                cand = cand - 3'(NUM_CH);
            end
            if (!grant_found && valid_ext[cand[1:0]]) begin
                grant_found = 1'b1;
                grant_ch    = cand[1:0];
            end
        end
    end

    assign grant_fire = (tx_state_reg == TX_ARB) && mux_synced_in && grant_found;

    // TX state register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            tx_state_reg <= TX_ARB;
        end else begin
            tx_state_reg <= tx_state_next;
        end
    end

    // TX next state: every grant is followed by exactly one tail cycle.
    always_comb begin
        tx_state_next = tx_state_reg;
        case (tx_state_reg)
            TX_ARB:  if (grant_fire) tx_state_next = TX_TAIL;
            TX_TAIL: tx_state_next = TX_ARB;
            default: tx_state_next = TX_ARB;
        endcase
    end

    // TX outputs: ready strobe, next payload word, drop indication.
    always_comb begin
        ready_ext     = '0;
        mux_data_next = 7'h00;
        tx_drop_next  = 1'b0;
        case (tx_state_reg)
            TX_ARB: begin
                if (grant_fire) begin
                    ready_ext[grant_ch] = rst_n_in;
                    mux_data_next       = {1'b1, grant_ch, ch_data[grant_ch][7:4]};
                end
            end
            TX_TAIL: begin
                if (mux_synced_in) begin
                    mux_data_next = {2'b01, ^tx_byte_reg, tx_byte_reg[3:0]};
                end else begin
                    tx_drop_next  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign tx_ready_out = ready_ext[NUM_CH-1:0];

    // TX datapath: latched byte, grant pointer and registered link word.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            last_grant_reg <= 2'(NUM_CH - 1);
            tx_byte_reg    <= 8'h00;
            mux_data_reg   <= 7'h00;
            tx_drop_reg    <= 1'b0;
        end else begin
            if (grant_fire) begin
                last_grant_reg <= grant_ch;
                tx_byte_reg    <= ch_data[grant_ch];
            end
            mux_data_reg <= mux_data_next;
            tx_drop_reg  <= tx_drop_next;
        end
    end

    assign mux_data_out = mux_data_reg;
    assign tx_drop_out  = tx_drop_reg;

    // Received word classification; nothing is decoded while the link is down.
    assign word_head = mux_synced_in && mux_data_in[6];
    assign word_tail = mux_synced_in && !mux_data_in[6] && mux_data_in[5];
    assign rx_byte   = {rx_hi_reg, mux_data_in[3:0]};

    // RX state register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rx_state_reg <= RX_WAIT_HEAD;
        end else begin
            rx_state_reg <= rx_state_next;
        end
    end

    // RX next state: a header always leads to WAIT_TAIL, anything else back to WAIT_HEAD.
    always_comb begin
        rx_state_next = RX_WAIT_HEAD;
        if (word_head) begin
            rx_state_next = RX_WAIT_TAIL;
        end
    end

    // RX outputs: good byte completion or framing/parity/channel error.
    always_comb begin
        rx_good     = 1'b0;
        rx_err_next = 1'b0;
        case (rx_state_reg)
            RX_WAIT_HEAD: rx_err_next = word_tail;
            RX_WAIT_TAIL: begin
                if (word_tail) begin
                    if ((mux_data_in[4] == ^rx_byte) && (int'(rx_ch_reg) < NUM_CH)) begin
                        rx_good = 1'b1;
                    end else begin
                        rx_err_next = 1'b1;
                    end
                end else begin
                    rx_err_next = mux_synced_in;
                end
            end
            default: ;
        endcase
    end

    assign rx_onehot = 4'b0001 << rx_ch_reg;

    // RX datapath: header capture, byte delivery and saturating error count.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rx_ch_reg      <= '0;
            rx_hi_reg      <= '0;
            rx_valid_reg   <= '0;
            rx_data_reg    <= 8'h00;
            rx_err_reg     <= 1'b0;
            rx_err_cnt_reg <= 8'h00;
        end else begin
            if (word_head) begin
                rx_ch_reg <= mux_data_in[5:4];
                rx_hi_reg <= mux_data_in[3:0];
            end
            rx_valid_reg <= rx_good ? rx_onehot[NUM_CH-1:0] : '0;
            if (rx_good) begin
                rx_data_reg <= rx_byte;
            end
            rx_err_reg <= rx_err_next;
            if (rx_err_next && (rx_err_cnt_reg != 8'hFF)) begin
                rx_err_cnt_reg <= rx_err_cnt_reg + 8'd1;
            end
        end
    end

    assign rx_valid_out   = rx_valid_reg;
    assign rx_data_out    = rx_data_reg;
    assign rx_err_out     = rx_err_reg;
    assign rx_err_cnt_out = rx_err_cnt_reg;

endmodule

// File: tb/tb_vhdci_mux_arbiter.sv
// Testbench for vhdci_mux_arbiter: directed scenarios plus randomized traffic,
// checked against a word-level behavioural model of the link framing.
module tb_vhdci_mux_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           synced;
    logic [N-1:0]   valid;
    logic [8*N-1:0] data;
    logic [N-1:0]   ready;
    logic [6:0]     mux_out;
    logic [6:0]     mux_in;
    logic [N-1:0]   rx_valid;
    logic [7:0]     rx_data;
    logic           tx_drop;
    logic           rx_err;
    logic [7:0]     rx_cnt;

    int vectors     = 0;
    int miscompares = 0;

    // Model state
    bit         m_in_tail;
    logic [7:0] m_byte;
    int         m_last;
    bit         m_pend;
    int         m_ch;
    logic [3:0] m_hi;

    // Expected values (ready for the current cycle, others after the edge)
    logic [N-1:0] obs_ready, exp_ready;
    logic [6:0]   exp_mux;
    logic         exp_drop, exp_err;
    logic [N-1:0] exp_rxv;
    logic [7:0]   exp_rxd;
    int           exp_cnt;

    always #5 clk = ~clk;

    vhdci_mux_arbiter #(.NUM_CH(N)) dut (
        .clk_in         (clk),
        .rst_n_in       (rst_n),
        .mux_synced_in  (synced),
        .tx_valid_in    (valid),
        .tx_data_in     (data),
        .tx_ready_out   (ready),
        .mux_data_out   (mux_out),
        .mux_data_in    (mux_in),
        .rx_valid_out   (rx_valid),
        .rx_data_out    (rx_data),
        .tx_drop_out    (tx_drop),
        .rx_err_out     (rx_err),
        .rx_err_cnt_out (rx_cnt)
    );

    task automatic model_reset();
        m_in_tail = 0; m_byte = 0; m_last = N - 1;
        m_pend = 0; m_ch = 0; m_hi = 0;
        exp_ready = 0; exp_mux = 0; exp_drop = 0; exp_err = 0;
        exp_rxv = 0; exp_rxd = 0; exp_cnt = 0;
    endtask

    task automatic do_reset();
        rst_n = 0; synced = 0; valid = 0; data = 0; mux_in = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        model_reset();
    endtask

    // One clock: sample ready mid-cycle, advance the model, return 1 ns after the edge.
    task automatic tick();
        logic [7:0] b;
        bit found, err;
        int c, g;
        @(negedge clk);
        obs_ready = ready;
        exp_ready = 0; exp_drop = 0; exp_mux = 7'h00;
        if (m_in_tail) begin
            if (synced) exp_mux = {2'b01, ^m_byte, m_byte[3:0]};
            else        exp_drop = 1;
            m_in_tail = 0;
        end else if (synced && (valid != 0)) begin
            found = 0; g = 0;
            for (int k = 1; k <= N; k++) begin
                c = (m_last + k) % N;
                if (!found && valid[c]) begin found = 1; g = c; end
            end
            exp_ready[g] = 1'b1;
            m_byte = data[8*g +: 8];
            exp_mux = {1'b1, 2'(g), m_byte[7:4]};
            m_last = g;
            m_in_tail = 1;
        end
        err = 0; exp_rxv = 0;
        if (!synced) begin
            m_pend = 0;
        end else if (mux_in[6]) begin
            if (m_pend) err = 1;
            m_pend = 1; m_ch = int'(mux_in[5:4]); m_hi = mux_in[3:0];
        end else if (mux_in[5]) begin
            if (!m_pend) err = 1;
            else begin
                b = {m_hi, mux_in[3:0]};
                if (mux_in[4] == ^b && m_ch < N) begin exp_rxv[m_ch] = 1'b1; exp_rxd = b; end
                else err = 1;
                m_pend = 0;
            end
        end else if (m_pend) begin
            err = 1; m_pend = 0;
        end
        exp_err = err;
        if (err && exp_cnt < 255) exp_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0; synced = 1; valid = '1; data = 32'hA5A5_A5A5; mux_in = 7'h53;
        #3;
        vectors++; if (ready !== 4'h0) begin miscompares++; $display("FAIL reset_ready: got %h expected 0", ready); end
        vectors++; if (mux_out !== 7'h00) begin miscompares++; $display("FAIL reset_mux: got %h expected 00", mux_out); end
        vectors++; if (rx_valid !== 4'h0) begin miscompares++; $display("FAIL reset_rxv: got %h expected 0", rx_valid); end
        vectors++; if (rx_data !== 8'h00) begin miscompares++; $display("FAIL reset_rxd: got %h expected 00", rx_data); end
        vectors++; if ({tx_drop, rx_err} !== 2'b00) begin miscompares++; $display("FAIL reset_pulses: got %b expected 00", {tx_drop, rx_err}); end
        vectors++; if (rx_cnt !== 8'h00) begin miscompares++; $display("FAIL reset_cnt: got %h expected 00", rx_cnt); end
        do_reset();
    endtask

    task automatic test_tx_single();
        do_reset();
        synced = 1; valid = 4'b0100; data = 32'h00A5_0000;
        tick();
        vectors++; if (obs_ready !== 4'b0100) begin miscompares++; $display("FAIL single_ready: got %b expected 0100", obs_ready); end
        vectors++; if (mux_out !== 7'h6A) begin miscompares++; $display("FAIL single_header: got %h expected 6a", mux_out); end
        valid = 0;
        tick();
        vectors++; if (obs_ready !== 4'b0000) begin miscompares++; $display("FAIL single_ready2: got %b expected 0000", obs_ready); end
        vectors++; if (mux_out !== 7'h25) begin miscompares++; $display("FAIL single_tail: got %h expected 25", mux_out); end
        tick();
        vectors++; if (mux_out !== 7'h00) begin miscompares++; $display("FAIL single_idle: got %h expected 00", mux_out); end
    endtask

    task automatic test_back_to_back();
        int order [5] = '{0, 1, 2, 3, 0};
        int seen = 0;
        do_reset();
        synced = 1; valid = 4'hF;
        for (int i = 0; i < 10; i++) begin
            data = $urandom;
            tick();
            vectors++; if (obs_ready !== exp_ready) begin miscompares++; $display("FAIL b2b_ready: cycle %0d got %b expected %b", i, obs_ready, exp_ready); end
            vectors++; if (mux_out !== exp_mux || mux_out === 7'h00) begin miscompares++; $display("FAIL b2b_mux: cycle %0d got %h expected %h", i, mux_out, exp_mux); end
            for (int c = 0; c < N; c++) begin
                if (obs_ready[c]) begin
                    vectors++;
                    if (c != order[seen]) begin miscompares++; $display("FAIL b2b_order: grant %0d got ch%0d expected ch%0d", seen, c, order[seen]); end
                    seen++;
                end
            end
        end
        valid = 0;
        tick();
    endtask

    task automatic test_rx_good();
        int cnt0;
        do_reset();
        synced = 1;
        cnt0 = exp_cnt;
        mux_in = 7'h53; tick();
        mux_in = 7'h2C; tick();
        vectors++; if (rx_valid !== 4'b0010) begin miscompares++; $display("FAIL rx_good_valid: got %b expected 0010", rx_valid); end
        vectors++; if (rx_data !== 8'h3C) begin miscompares++; $display("FAIL rx_good_data: got %h expected 3c", rx_data); end
        vectors++; if (rx_cnt !== 8'(cnt0) || rx_err !== 1'b0) begin miscompares++; $display("FAIL rx_good_cnt: got %0d/%b expected %0d/0", rx_cnt, rx_err, cnt0); end
        mux_in = 7'h00; tick();
        vectors++; if (rx_valid !== 4'b0000 || rx_data !== 8'h3C) begin miscompares++; $display("FAIL rx_good_hold: got %b/%h expected 0000/3c", rx_valid, rx_data); end
    endtask

    task automatic test_rx_err_sat();
        do_reset();
        synced = 1;
        for (int i = 0; i < 300; i++) begin
            mux_in = 7'h53; tick();
            mux_in = 7'h3C; tick();
            vectors++;
            if (rx_err !== 1'b1 || rx_valid !== 4'b0000 || rx_cnt !== 8'(exp_cnt)) begin
                miscompares++;
                $display("FAIL rx_bad_parity: pair %0d got err=%b valid=%b cnt=%0d expected err=1 valid=0000 cnt=%0d", i, rx_err, rx_valid, rx_cnt, exp_cnt);
            end
        end
        mux_in = 7'h00; tick();
        vectors++; if (rx_cnt !== 8'd255 || rx_err !== 1'b0) begin miscompares++; $display("FAIL rx_saturate: got %0d/%b expected 255/0", rx_cnt, rx_err); end
    endtask

    task automatic test_tx_drop();
        do_reset();
        synced = 1; valid = 4'b0001; data = 32'h0000_00C3;
        tick();
        vectors++; if (obs_ready !== 4'b0001 || mux_out !== 7'h4C) begin miscompares++; $display("FAIL drop_grant: got %b/%h expected 0001/4c", obs_ready, mux_out); end
        synced = 0;
        tick();
        vectors++; if (tx_drop !== 1'b1 || mux_out !== 7'h00) begin miscompares++; $display("FAIL drop_pulse: got %b/%h expected 1/00", tx_drop, mux_out); end
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++; if (obs_ready !== 4'b0000 || tx_drop !== 1'b0 || mux_out !== 7'h00) begin miscompares++; $display("FAIL drop_unsynced: got %b/%b/%h expected 0000/0/00", obs_ready, tx_drop, mux_out); end
        end
        synced = 1;
        tick();
        vectors++; if (obs_ready !== 4'b0001 || mux_out !== exp_mux) begin miscompares++; $display("FAIL drop_resync: got %b/%h expected 0001/%h", obs_ready, mux_out, exp_mux); end
        valid = 0;
        tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        synced = 1;
        mux_in = 7'h53; tick();
        mux_in = 7'h2C; tick();
        valid = 4'b0010; data = 32'h0000_7700; mux_in = 7'h53; tick();
        vectors++; if (mux_out !== exp_mux || rx_cnt !== 8'(exp_cnt) || rx_data !== 8'h3C) begin miscompares++; $display("FAIL areset_setup: got %h/%0d/%h expected %h/%0d/3c", mux_out, rx_cnt, rx_data, exp_mux, exp_cnt); end
        #2 rst_n = 0;
        #1;
        vectors++;
        if (mux_out !== 7'h00 || rx_data !== 8'h00 || rx_cnt !== 8'h00 || ready !== 4'h0 ||
            rx_valid !== 4'h0 || tx_drop !== 1'b0 || rx_err !== 1'b0) begin
            miscompares++;
            $display("FAIL areset_outputs: got mux=%h rxd=%h cnt=%h rdy=%b rxv=%b drop=%b err=%b expected all zero",
                     mux_out, rx_data, rx_cnt, ready, rx_valid, tx_drop, rx_err);
        end
        do_reset();
    endtask

    task automatic test_random();
        int r;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            synced = ($urandom_range(0, 9) != 0);
            valid  = 4'($urandom);
            data   = $urandom;
            r = $urandom_range(0, 9);
            if (r < 4)      mux_in = {1'b1, 6'($urandom)};
            else if (r < 8) begin
                mux_in = {2'b01, 1'b0, 4'($urandom)};
                mux_in[4] = (r < 7) ? ^{m_hi, mux_in[3:0]} : 1'($urandom);
            end
            else if (r < 9) mux_in = 7'h00;
            else            mux_in = 7'($urandom);
            tick();
            vectors++; if (obs_ready !== exp_ready) begin miscompares++; $display("FAIL rnd_ready: cycle %0d got %b expected %b", i, obs_ready, exp_ready); end
            vectors++; if (mux_out !== exp_mux) begin miscompares++; $display("FAIL rnd_mux: cycle %0d got %h expected %h", i, mux_out, exp_mux); end
            vectors++; if (tx_drop !== exp_drop) begin miscompares++; $display("FAIL rnd_drop: cycle %0d got %b expected %b", i, tx_drop, exp_drop); end
            vectors++; if (rx_valid !== exp_rxv) begin miscompares++; $display("FAIL rnd_rxv: cycle %0d got %b expected %b", i, rx_valid, exp_rxv); end
            vectors++; if (rx_data !== exp_rxd) begin miscompares++; $display("FAIL rnd_rxd: cycle %0d got %h expected %h", i, rx_data, exp_rxd); end
            vectors++; if (rx_err !== exp_err) begin miscompares++; $display("FAIL rnd_err: cycle %0d got %b expected %b", i, rx_err, exp_err); end
            vectors++; if (rx_cnt !== 8'(exp_cnt)) begin miscompares++; $display("FAIL rnd_cnt: cycle %0d got %0d expected %0d", i, rx_cnt, exp_cnt); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_tx_single();
        test_back_to_back();
        test_rx_good();
        test_rx_err_sat();
        test_tx_drop();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
